uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver for the serial link: recovers 8N1 frames from the asynchronous `rx` line using a 16x oversampling tick supplied by the baud generator. It presents each received byte through a one-entry valid/ready holding register. It reports framing errors and overruns as single-cycle pulses. It sits between the pad-side `rx` input and the byte-level consumer (FIFO or control logic) and is clocked in the same `clk` domain as the tick source.

## Interface
- `DATA_BITS`, default 8: data bits per frame, LSB first. No parity; one stop bit.
- `OVERSAMPLE`, default 16: ticks per bit period. Must be even and ≥ 4.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `tick16` in 1: single-cycle pulse at OVERSAMPLE × baud rate. It is never high on two consecutive cycles.
- `rx` in 1: asynchronous serial input; idles high.
- `rx_data` out DATA_BITS: last accepted byte. Stable while `rx_valid`=1.
- `rx_valid` out 1: holding register full.
- `rx_ready` in 1: consumer accepts `rx_data` when `rx_valid` && `rx_ready`.
- `frame_err` out 1: 1-cycle pulse; stop bit sampled low.
- `overrun` out 1: 1-cycle pulse; a byte completed while the holding register was full and not being drained.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Synchronizer: `rx` passes through 2 flops to give `rx_s`. Both flops reset to 1. All decisions use `rx_s`.
- The state machine and the tick counter `tcnt` (width `$clog2(OVERSAMPLE)`) advance only on cycles with `tick16`=1.
- States:
  - IDLE: on a tick with `rx_s`=0, go to START and set `tcnt`=0.
  - START: on the tick where `tcnt`=OVERSAMPLE/2−1 (mid start bit), check `rx_s`.
    - `rx_s`=0: go to DATA with `tcnt`=0 and `bcnt`=0.
    - `rx_s`=1: glitch; return to IDLE. No flags.
  - DATA: on the tick where `tcnt`=OVERSAMPLE−1, shift `rx_s` into the MSB of the shift register (LSB-first reception) and clear `tcnt`.
    - After bit DATA_BITS−1, go to STOP.
  - STOP: on the tick where `tcnt`=OVERSAMPLE−1, sample `rx_s`.
    - 1: deliver the byte (see below), then go to IDLE.
    - 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: go to IDLE on the first tick with `rx_s`=1. A held-low break line therefore yields exactly one `frame_err`.
- Delivery, evaluated in the cycle the stop bit is accepted:
  - `rx_valid`=0, or `rx_valid`=1 && `rx_ready`=1: load `rx_data`, set `rx_valid`=1.
  - `rx_valid`=1 && `rx_ready`=0: keep the old byte, drop the new one, pulse `overrun`.
- Drain: `rx_valid`=1 && `rx_ready`=1 with no delivery in the same cycle clears `rx_valid` on the next edge.
- `rst` mid-frame: on the next edge, state=IDLE, counters=0, shift register=0, holding register cleared. A frame in progress is lost. No flags are raised.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0.
- Sampling point: mid-bit, i.e. OVERSAMPLE/2 ticks after the detected falling edge plus k·OVERSAMPLE ticks.
- Edge-detection uncertainty is one tick period plus 2 `clk` cycles of synchronizer delay.
- `rx_valid`, `frame_err` and `overrun` are registered. They assert on the `clk` edge following the stop-bit sampling tick.
- Back-to-back frames: the state returns to IDLE at mid stop bit, so a start bit immediately after the stop bit is detected with no lost ticks.
- `tick16` while `rst`=1 is ignored.

## Structure
- Package `uart_pkg` holds:
  - the state enum: IDLE, START, DATA, STOP, WAIT_HIGH;
  - the default constants DATA_BITS=8 and OVERSAMPLE=16.
- The transmitter shares this package.
- Sub-module `sync_2ff`: a reusable 2-flop synchronizer with a reset-value parameter, instantiated with reset value 1.
- Everything else is inline in `uart_rx`, roughly 150–200 lines.

## Test plan
- Single byte: drive `tick16` every 4th `clk`, send frame 0xA5 with `rx_ready`=1.
  - Required: one `rx_valid` with `rx_data`=0xA5, `frame_err`=0, `overrun`=0, `busy` low after mid stop bit.
- Back-to-back: send 0x00, 0xFF, 0x3C with no idle gap, `rx_ready` always 1.
  - Required: three deliveries in order, no flags.
- Glitch rejection: pulse `rx` low for 3 tick periods (< OVERSAMPLE/2), then high.
  - Required: state returns to IDLE, no `rx_valid`, no `frame_err`.
- Framing/break: send 0x55 with stop bit 0, then hold `rx` low for 40 bit times, then release.
  - Required: exactly one `frame_err` pulse, no `rx_valid`, `busy` stays high until `rx` returns high.
- Overrun and simultaneous drain:
  - Send 0x11 and 0x22 with `rx_ready`=0. Required: `rx_data` stays 0x11 and `overrun` pulses once.
  - Repeat, raising `rx_ready` in the delivery cycle of 0x22. Required: `rx_data`=0x22, `rx_valid` stays 1, no `overrun`.
- Reset mid-frame: assert `rst` for 1 cycle during data bit 4 of 0x96, then send 0x5A.
  - Required: all outputs at reset values, next delivery is 0x5A, no flags.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver and transmitter: frame state
// encoding and default frame geometry.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_e;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; RESET_VAL sets the
// value both flops take under reset so idle-high lines stay quiet.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, a one-entry valid/ready holding
// register, and single-cycle framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick16,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic rx_s;

  uart_state_e          state, state_n;
  logic [TW-1:0]        tcnt, tcnt_n;
  logic [BW-1:0]        bcnt, bcnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 deliver;
  logic                 stop_bad;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tcnt  <= '0;
      bcnt  <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      tcnt  <= tcnt_n;
      bcnt  <= bcnt_n;
      shreg <= shreg_n;
    end
  end

  // Leaving STOP at mid stop bit lets a following start edge be caught at once.
  always_comb begin
    state_n  = state;
    tcnt_n   = tcnt;
    bcnt_n   = bcnt;
    shreg_n  = shreg;
    deliver  = 1'b0;
    stop_bad = 1'b0;
    if (tick16) begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n = START;
            tcnt_n  = '0;
          end
        end
        START: begin
          if (tcnt == T_MID) begin
            tcnt_n = '0;
            if (!rx_s) begin
              state_n = DATA;
              bcnt_n  = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
        DATA: begin
          if (tcnt == T_END) begin
            tcnt_n  = '0;
            shreg_n = (shreg >> 1) | (DATA_BITS'(rx_s) << (DATA_BITS - 1));
            if (bcnt == B_LAST) begin
              state_n = STOP;
            end else begin
              bcnt_n = bcnt + 1'b1;
            end
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
        STOP: begin
          if (tcnt == T_END) begin
            tcnt_n = '0;
            if (rx_s) begin
              deliver = 1'b1;
              state_n = IDLE;
            end else begin
              stop_bad = 1'b1;
              state_n  = WAIT_HIGH;
            end
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // A delivery into a full register is accepted only if the consumer drains it
  // in the same cycle; otherwise the older byte wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit-serially, expected bytes
// are queued at issue time and a monitor checks every valid/ready handshake.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick16;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int fe_count = 0;
  int ov_count = 0;
  int del_count = 0;
  int base_fe, base_ov, base_del;
  logic [7:0] exp_queue[$];

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick16    (tick16),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // One tick16 cycle in every four clk cycles.
  initial begin
    tick16 = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick16 = 1'b1;
      @(negedge clk);
      tick16 = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Sampled 1 time unit after the falling edge so inputs and outputs are settled.
  initial begin
    logic [7:0] exp_byte;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (frame_err) fe_count++;
        if (overrun) ov_count++;
        if (rx_valid && rx_ready) begin
          del_count++;
          if (exp_queue.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_delivery: got 0x%0h, expected no byte", rx_data);
          end else begin
            exp_byte = exp_queue.pop_front();
            checkOutput("rx_data", {24'h0, rx_data}, {24'h0, exp_byte});
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic snapshot();
    base_fe  = fe_count;
    base_ov  = ov_count;
    base_del = del_count;
  endtask

  // Return on the falling edge just after a tick cycle, fixing the tick phase.
  task automatic alignToTick();
    do @(posedge clk); while (!tick16);
    @(negedge clk);
  endtask

  // Drives one frame; rx is left at the stop-bit level afterwards.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_rx_data", {24'h0, rx_data}, 32'h0);
    checkOutput("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    checkOutput("reset_frame_err", {31'h0, frame_err}, 32'h0);
    checkOutput("reset_overrun", {31'h0, overrun}, 32'h0);
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);

    $display("[TB] single byte 0xA5");
    snapshot();
    exp_queue.push_back(8'hA5);
    alignToTick();
    fork
      applyStimulus(8'hA5, 1'b1);
      begin
        repeat (320) @(negedge clk);
        checkOutput("single_busy_mid", {31'h0, busy}, 32'h1);
      end
    join
    checkOutput("single_busy_after", {31'h0, busy}, 32'h0);
    checkOutput("single_deliveries", del_count - base_del, 1);
    checkOutput("single_frame_err", fe_count - base_fe, 0);
    checkOutput("single_overrun", ov_count - base_ov, 0);

    $display("[TB] back-to-back 0x00 0xFF 0x3C");
    snapshot();
    exp_queue.push_back(8'h00);
    exp_queue.push_back(8'hFF);
    exp_queue.push_back(8'h3C);
    alignToTick();
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'h3C, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("b2b_deliveries", del_count - base_del, 3);
    checkOutput("b2b_flags", (fe_count - base_fe) + (ov_count - base_ov), 0);

    $display("[TB] glitch rejection");
    snapshot();
    alignToTick();
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    checkOutput("glitch_busy_during", {31'h0, busy}, 32'h1);
    repeat (2 * BIT_CLKS) @(negedge clk);
    checkOutput("glitch_busy_after", {31'h0, busy}, 32'h0);
    checkOutput("glitch_deliveries", del_count - base_del, 0);
    checkOutput("glitch_frame_err", fe_count - base_fe, 0);

    $display("[TB] framing error and break");
    snapshot();
    alignToTick();
    applyStimulus(8'h55, 1'b0);
    repeat (40 * BIT_CLKS) @(negedge clk);
    checkOutput("break_busy_held", {31'h0, busy}, 32'h1);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    checkOutput("break_busy_released", {31'h0, busy}, 32'h0);
    checkOutput("break_frame_err", fe_count - base_fe, 1);
    checkOutput("break_deliveries", del_count - base_del, 0);
    checkOutput("break_valid", {31'h0, rx_valid}, 32'h0);

    $display("[TB] overrun with consumer stalled");
    snapshot();
    rx_ready = 1'b0;
    exp_queue.push_back(8'h11);
    alignToTick();
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("ovr_valid", {31'h0, rx_valid}, 32'h1);
    checkOutput("ovr_data_kept", {24'h0, rx_data}, 32'h11);
    checkOutput("ovr_pulses", ov_count - base_ov, 1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    checkOutput("ovr_drained", {31'h0, rx_valid}, 32'h0);

    $display("[TB] drain in the delivery cycle");
    snapshot();
    exp_queue.push_back(8'h11);
    exp_queue.push_back(8'h22);
    alignToTick();
    applyStimulus(8'h11, 1'b1);
    fork
      applyStimulus(8'h22, 1'b1);
      begin
        repeat (611) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    checkOutput("drain_valid", {31'h0, rx_valid}, 32'h1);
    checkOutput("drain_data", {24'h0, rx_data}, 32'h22);
    checkOutput("drain_overrun", ov_count - base_ov, 0);
    checkOutput("drain_handshakes", del_count - base_del, 1);
    rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);

    $display("[TB] reset mid-frame");
    rx_ready = 1'b0;
    alignToTick();
    applyStimulus(8'h77, 1'b1);
    checkOutput("pre_reset_valid", {31'h0, rx_valid}, 32'h1);
    checkOutput("pre_reset_data", {24'h0, rx_data}, 32'h77);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'h96 >> i);
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_valid", {31'h0, rx_valid}, 32'h0);
    checkOutput("rst_data", {24'h0, rx_data}, 32'h0);
    checkOutput("rst_flags", {30'h0, frame_err, overrun}, 32'h0);
    repeat (10 * BIT_CLKS) @(negedge clk);
    snapshot();
    rx_ready = 1'b1;
    exp_queue.push_back(8'h5A);
    alignToTick();
    applyStimulus(8'h5A, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("post_rst_deliveries", del_count - base_del, 1);
    checkOutput("post_rst_flags", (fe_count - base_fe) + (ov_count - base_ov), 0);

    checkOutput("queue_empty", exp_queue.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
